// File: rtl/seq_decoder_scan.sv
// Purpose: registered address decoder (one-hot / thermometer) with an autonomous one-hot scan mode.
// Latency: out/out_valid/addr_err update 1 cycle after accept; scan position steps every DWELL cycles.
// Backpressure: in_ready only in decode modes while idle; unaccepted addresses are dropped, never queued.
module seq_decoder_scan #(
   parameter int N     = 8,
   parameter int DWELL = 4,
   localparam int ADDR_WIDTH = (N > 1) ? $clog2(N) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic [1:0]            mode,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ADDR_WIDTH-1:0] address,
   output logic [N-1:0]          out,
   output logic                  out_valid,
   output logic                  addr_err,
   output logic                  scan_wrap,
   output logic [ADDR_WIDTH-1:0] cur_addr
);

   localparam int CNT_WIDTH = (DWELL > 1) ? $clog2(DWELL) : 1;

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                state, state_next;
   logic [CNT_WIDTH-1:0]  cnt;
   logic [ADDR_WIDTH-1:0] pos;
   logic [ADDR_WIDTH-1:0] pos_next;
   logic                  cnt_last;
   logic                  accept;
   logic                  addr_bad;
   logic [N-1:0]          onehot_vec;
   logic [N-1:0]          therm_vec;
   logic [N-1:0]          scan_vec;

   // Decode the incoming address and the next scan position into select vectors
   always_comb begin
      onehot_vec = '0;
      therm_vec  = '0;
      scan_vec   = '0;
      addr_bad   = (int'(address) >= N);
      cnt_last   = (cnt == CNT_WIDTH'(DWELL - 1));
      pos_next   = (pos == ADDR_WIDTH'(N - 1)) ? '0 : pos + 1'b1;
      for (int i = 0; i < N; i++) begin
         onehot_vec[i] = (int'(address) == i);
         therm_vec[i]  = (i <= int'(address));
         scan_vec[i]   = (int'(pos_next) == i);
      end
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next state and handshake; ready is also held low while reset is asserted
   always_comb begin
      state_next = IDLE;
      in_ready   = 1'b0;
      if (enable && mode == 2'b10) state_next = SCAN;
      if (!rst && enable && !mode[1] && state == IDLE) in_ready = 1'b1;
   end

   assign accept = in_valid && in_ready;

   // Output, scan counter and position registers; pulses default low every cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out       <= '0;
         out_valid <= 1'b0;
         addr_err  <= 1'b0;
         scan_wrap <= 1'b0;
         cur_addr  <= '0;
         cnt       <= '0;
         pos       <= '0;
      end else begin
         out_valid <= 1'b0;
         addr_err  <= 1'b0;
         scan_wrap <= 1'b0;
         if (!enable) begin
            out      <= '0;
            cur_addr <= '0;
            cnt      <= '0;
            pos      <= '0;
         end else if (mode == 2'b10) begin
            if (state == IDLE) begin
               // entering scan always restarts at position 0 with a full dwell
               out      <= N'(1);
               cur_addr <= '0;
               cnt      <= '0;
               pos      <= '0;
            end else if (cnt_last) begin
               cnt       <= '0;
               pos       <= pos_next;
               out       <= scan_vec;
               cur_addr  <= pos_next;
               scan_wrap <= (pos_next == '0);
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else if (state == SCAN) begin
            // leaving scan: clear the select and the scan position
            out      <= '0;
            cur_addr <= '0;
            cnt      <= '0;
            pos      <= '0;
         end else if (accept) begin
            if (addr_bad) begin
               out      <= '0;
               addr_err <= 1'b1;
            end else begin
               out       <= mode[0] ? therm_vec : onehot_vec;
               out_valid <= 1'b1;
               cur_addr  <= address;
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_decoder_scan.sv
// Bench for seq_decoder_scan: three instances (N=8/DWELL=4, N=6/DWELL=2, N=4/DWELL=2) share stimulus.
// Expected values come from a position-over-time model of the decoder and scan behaviour.
// Directed steps cover decode, errors, hold, scan/wrap, enable drop and async reset, then random traffic.
module tb_seq_decoder_scan;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [1:0] mode = 2'b00;
   logic       in_valid = 1'b0;
   logic [2:0] address = 3'd0;

   logic       rdy8, rdy6, rdy4;
   logic [7:0] out8;
   logic [5:0] out6;
   logic [3:0] out4;
   logic       ov8, ov6, ov4, ae8, ae6, ae4, sw8, sw6, sw4;
   logic [2:0] cur8, cur6;
   logic [1:0] cur4;

   int errors = 0;
   int checks = 0;

   int NS [3] = '{8, 6, 4};
   int DS [3] = '{4, 2, 2};
   int AWS[3] = '{3, 3, 2};

   // model state: scanning flag, cycles spent in scan, and expected registered outputs
   bit m_scan[3];
   int m_t[3];
   int m_out[3];
   int m_cur[3];
   bit m_ov[3];
   bit m_ae[3];
   bit m_sw[3];

   always #5 clk = ~clk;

   seq_decoder_scan #(.N(8), .DWELL(4)) u8 (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .in_valid(in_valid),
      .in_ready(rdy8), .address(address), .out(out8), .out_valid(ov8),
      .addr_err(ae8), .scan_wrap(sw8), .cur_addr(cur8));

   seq_decoder_scan #(.N(6), .DWELL(2)) u6 (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .in_valid(in_valid),
      .in_ready(rdy6), .address(address), .out(out6), .out_valid(ov6),
      .addr_err(ae6), .scan_wrap(sw6), .cur_addr(cur6));

   seq_decoder_scan #(.N(4), .DWELL(2)) u4 (
      .clk(clk), .rst(rst), .enable(enable), .mode(mode), .in_valid(in_valid),
      .in_ready(rdy4), .address(address[1:0]), .out(out4), .out_valid(ov4),
      .addr_err(ae4), .scan_wrap(sw4), .cur_addr(cur4));

   task automatic check(input string tag, input int i, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s N=%0d got=%0h exp=%0h", tag, NS[i], got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_scan[i] = 1'b0; m_t[i] = 0; m_out[i] = 0; m_cur[i] = 0;
         m_ov[i] = 1'b0; m_ae[i] = 1'b0; m_sw[i] = 1'b0;
      end
   endtask

   // One clock of the reference behaviour for instance i, using the inputs seen at the edge
   task automatic model_step(input int i);
      int n, d, a, p;
      n = NS[i];
      d = DS[i];
      a = int'(address) & ((1 << AWS[i]) - 1);
      m_ov[i] = 1'b0; m_ae[i] = 1'b0; m_sw[i] = 1'b0;
      if (!enable) begin
         m_scan[i] = 1'b0; m_out[i] = 0; m_cur[i] = 0;
      end else if (mode == 2'b10) begin
         if (!m_scan[i]) begin
            m_scan[i] = 1'b1;
            m_t[i] = 0;
         end else begin
            m_t[i]++;
         end
         p = (m_t[i] / d) % n;
         m_out[i] = 1 << p;
         m_cur[i] = p;
         m_sw[i] = (m_t[i] > 0) && (m_t[i] % (d * n) == 0);
      end else if (m_scan[i]) begin
         m_scan[i] = 1'b0; m_out[i] = 0; m_cur[i] = 0;
      end else if (in_valid && !mode[1]) begin
         if (a >= n) begin
            m_out[i] = 0;
            m_ae[i] = 1'b1;
         end else begin
            m_out[i] = mode[0] ? ((2 << a) - 1) : (1 << a);
            m_ov[i] = 1'b1;
            m_cur[i] = a;
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      for (int i = 0; i < 3; i++) begin
         logic [31:0] o, c;
         logic ov, ae, sw;
         case (i)
            0: begin o = 32'(out8); c = 32'(cur8); ov = ov8; ae = ae8; sw = sw8; end
            1: begin o = 32'(out6); c = 32'(cur6); ov = ov6; ae = ae6; sw = sw6; end
            default: begin o = 32'(out4); c = 32'(cur4); ov = ov4; ae = ae4; sw = sw4; end
         endcase
         check({tag, ".out"}, i, o, 32'(m_out[i]));
         check({tag, ".cur_addr"}, i, c, 32'(m_cur[i]));
         check({tag, ".out_valid"}, i, 32'(ov), 32'(m_ov[i]));
         check({tag, ".addr_err"}, i, 32'(ae), 32'(m_ae[i]));
         check({tag, ".scan_wrap"}, i, 32'(sw), 32'(m_sw[i]));
      end
   endtask

   task automatic check_ready(input string tag);
      for (int i = 0; i < 3; i++) begin
         logic r;
         bit   e;
         case (i)
            0: r = rdy8;
            1: r = rdy6;
            default: r = rdy4;
         endcase
         e = !rst && enable && !mode[1] && !m_scan[i];
         check({tag, ".in_ready"}, i, 32'(r), 32'(e));
      end
   endtask

   // Drive inputs, check ready before the edge, advance the model, check outputs after the edge
   task automatic step(input string tag, input bit en, input bit [1:0] md, input bit v, input bit [2:0] a);
      enable = en; mode = md; in_valid = v; address = a;
      #1;
      check_ready(tag);
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      bit [1:0] rmode;
      model_reset();
      #2;
      check_outputs("reset");
      check_ready("reset");
      #1 rst = 1'b0;

      // back-to-back one-hot decode of 0..7 (N=6 flags 6,7; N=4 sees address[1:0])
      for (int a = 0; a < 8; a++) step("onehot", 1'b1, 2'b00, 1'b1, 3'(a));
      for (int k = 0; k < 3; k++) step("idle_hold", 1'b1, 2'b00, 1'b0, 3'd2);

      // thermometer decode
      step("therm3", 1'b1, 2'b01, 1'b1, 3'd3);
      step("therm0", 1'b1, 2'b01, 1'b1, 3'd0);
      step("therm5", 1'b1, 2'b01, 1'b1, 3'd5);

      // out-of-range address for N=6 keeps cur_addr
      step("err7", 1'b1, 2'b00, 1'b1, 3'd7);
      step("after_err", 1'b1, 2'b00, 1'b0, 3'd7);

      // hold mode ignores valid addresses
      step("preload", 1'b1, 2'b00, 1'b1, 3'd2);
      for (int k = 0; k < 3; k++) step("hold", 1'b1, 2'b11, 1'b1, 3'd6);

      // scan long enough to wrap every instance
      for (int k = 0; k < 40; k++) step("scan", 1'b1, 2'b10, 1'b1, 3'd1);

      // drop enable mid-scan, then restart from position 0
      step("scan_off", 1'b0, 2'b10, 1'b0, 3'd0);
      for (int k = 0; k < 12; k++) step("scan_restart", 1'b1, 2'b10, 1'b0, 3'd0);

      // leave scan with a valid address present: not accepted on the exit cycle
      step("scan_exit", 1'b1, 2'b00, 1'b1, 3'd4);
      step("post_exit", 1'b1, 2'b00, 1'b1, 3'd4);
      step("dis_idle", 1'b0, 2'b00, 1'b1, 3'd1);

      // random traffic with sticky mode so scans run for a while
      rmode = 2'b00;
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(0, 7) == 0) rmode = 2'($urandom_range(0, 3));
         step("rand", $urandom_range(0, 15) != 0, rmode, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      end

      // asynchronous reset between edges in the middle of a scan
      for (int k = 0; k < 7; k++) step("pre_rst_scan", 1'b1, 2'b10, 1'b0, 3'd0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_outputs("async_rst");
      check_ready("async_rst");
      #2 rst = 1'b0;
      step("post_rst_idle", 1'b1, 2'b00, 1'b1, 3'd5);
      for (int k = 0; k < 5; k++) step("post_rst_scan", 1'b1, 2'b10, 1'b0, 3'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
